if_id_queue: RTL



---
 rtl/if_id_queue.sv | 91 +++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// if_id_queue: small circular FIFO decoupling instruction fetch from decode.
// Holds {pc, inst} pairs and presents the oldest pair to decode through a
// valid/ready handshake. A synchronous flush discards everything queued.
module if_id_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_inst,
  output logic              if_ready,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst,
  input  logic              id_ready,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] pc_mem_q   [DEPTH];
  logic [DATA_W-1:0] inst_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  logic push, pop;

  // Handshake and head-of-queue outputs; empty queue presents a zero NOP.
  always_comb begin
    if_ready = (count_q != FULL_CNT);
    id_valid = (count_q != '0);
    push     = if_valid && if_ready;
    pop      = id_valid && id_ready;
    id_pc    = '0;
    id_inst  = '0;
    if (id_valid) begin
      id_pc   = pc_mem_q[rd_ptr_q];
      id_inst = inst_mem_q[rd_ptr_q];
    end
  end

  // Next-state for pointers and occupancy; flush clears, push/pop advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      pc_mem_q[wr_ptr_q]   <= if_pc;
      inst_mem_q[wr_ptr_q] <= if_inst;
    end
  end

  assign count = count_q;

endmodule
